// File: rtl/wb_pkg.sv
// Shared types and default widths for the write-back arbiter.
// The NORMAL/DRAIN state type is only used when WB_STARVE_GUARD_EN is defined.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for load/NPU write-back results.
// It also exposes per-entry valid bits and destination registers for hazard tracking.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_rd,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [ADDR_W-1:0]        head_rd,
    output logic [DATA_W-1:0]        head_data,
    output logic [DEPTH-1:0]         entry_valid,
    output logic [DEPTH*ADDR_W-1:0]  entry_rd
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  count;
    logic [IDX_W-1:0]  offset;
    logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
    logic [ADDR_W-1:0] rd_mem_d   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

    assign head_rd   = rd_mem_q[rd_ptr_q[IDX_W-1:0]];
    assign head_data = data_mem_q[rd_ptr_q[IDX_W-1:0]];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        if (push && !full) begin
            rd_mem_d[wr_ptr_q[IDX_W-1:0]]   = push_rd;
            data_mem_d[wr_ptr_q[IDX_W-1:0]] = push_data;
            wr_ptr_d                        = wr_ptr_q + PTR_W'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        entry_valid = '0;
        entry_rd    = '0;
        offset      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = IDX_W'(i) - rd_ptr_q[IDX_W-1:0];
            entry_valid[i] = ({1'b0, offset} < count);
            entry_rd[i*ADDR_W +: ADDR_W] = rd_mem_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results win the register file port, load/NPU results queue in wb_fifo.
// Define WB_STARVE_GUARD_EN to add the NORMAL/DRAIN starvation guard and the STARVE_LIMIT parameter.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int FIFO_DEPTH = 4
`ifdef WB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [ADDR_W-1:0]     alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_W-1:0]     lsu_rd,
    input  logic [DATA_W-1:0]     lsu_data,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_rd_addr,
    output logic [DATA_W-1:0]     rf_rd_data,
    output logic [2**ADDR_W-1:0]  pend_mask,
    output logic                  alu_stall
);

    localparam int NREG = 2**ADDR_W;

    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_pop;
    logic                         lsu_push;
    logic [ADDR_W-1:0]            head_rd;
    logic [DATA_W-1:0]            head_data;
    logic [FIFO_DEPTH-1:0]        entry_valid;
    logic [FIFO_DEPTH*ADDR_W-1:0] entry_rd;
    logic                         alu_wr;
    logic                         alu_sel;
    logic                         rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]            rf_rd_addr_q, rf_rd_addr_d;
    logic [DATA_W-1:0]            rf_rd_data_q, rf_rd_data_d;
    logic [NREG-1:0]              pend_mask_c;

    // Writes to r0 are dropped here; an r0 load still completes its handshake.
    assign alu_wr    = alu_valid && (alu_rd != '0);
    assign lsu_ready = !fifo_full;
    assign lsu_push  = lsu_valid && !fifo_full && (lsu_rd != '0);

    wb_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (lsu_push),
        .push_rd     (lsu_rd),
        .push_data   (lsu_data),
        .pop         (fifo_pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_rd     (head_rd),
        .head_data   (head_data),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    wb_state_t        state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             alu_stall_q, alu_stall_d;

    // While draining, the FIFO owns the port and any ALU result is ignored.
    assign alu_sel   = alu_wr && (state_q == NORMAL);
    assign fifo_pop  = !fifo_empty && !alu_sel;
    assign alu_stall = alu_stall_q;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        alu_stall_d  = alu_stall_q;
        case (state_q)
            NORMAL: begin
                if (fifo_empty || fifo_pop) begin
                    starve_cnt_d = '0;
                end else begin
                    starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    if (starve_cnt_d == CNT_W'(STARVE_LIMIT)) begin
                        state_d     = DRAIN;
                        alu_stall_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d      = NORMAL;
                    alu_stall_d  = 1'b0;
                    starve_cnt_d = '0;
                end
            end
            default: begin
                state_d      = NORMAL;
                alu_stall_d  = 1'b0;
                starve_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= NORMAL;
            starve_cnt_q <= '0;
            alu_stall_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            alu_stall_q  <= alu_stall_d;
        end
    end
`else
    assign alu_sel   = alu_wr;
    assign fifo_pop  = !fifo_empty && !alu_wr;
    assign alu_stall = 1'b0;
`endif

    always_comb begin
        rf_we_d      = 1'b0;
        rf_rd_addr_d = rf_rd_addr_q;
        rf_rd_data_d = rf_rd_data_q;
        if (alu_sel) begin
            rf_we_d      = 1'b1;
            rf_rd_addr_d = alu_rd;
            rf_rd_data_d = alu_data;
        end else if (fifo_pop) begin
            rf_we_d      = 1'b1;
            rf_rd_addr_d = head_rd;
            rf_rd_data_d = head_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_q      <= 1'b0;
            rf_rd_addr_q <= '0;
            rf_rd_data_q <= '0;
        end else begin
            rf_we_q      <= rf_we_d;
            rf_rd_addr_q <= rf_rd_addr_d;
            rf_rd_data_q <= rf_rd_data_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_rd_addr = rf_rd_addr_q;
    assign rf_rd_data = rf_rd_data_q;

    // Every write not yet committed, queued or in the output stage, marks its register busy.
    always_comb begin
        pend_mask_c = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) begin
                pend_mask_c[entry_rd[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (rf_we_q) begin
            pend_mask_c[rf_rd_addr_q] = 1'b1;
        end
    end

    assign pend_mask = pend_mask_c;

endmodule
